// File: rtl/wt_cache_pkg.sv
// Purpose: shared types for the dcache load-port arbiter (request/response structs, owner tag).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wt_cache_pkg;

  // Upper bound on granted-but-unanswered requests any arbiter instance may track.
  localparam int unsigned DCACHE_ARB_MAX_OUTST = 8;

  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_TAG_WIDTH   = 20;
  localparam int unsigned DCACHE_DATA_WIDTH  = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_PF   = 2'd2
  } port_owner_e;

  // Requester -> cache: request phase (index/data_req) and tag phase (tag/tag_valid/kill).
  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0]  address_index;
    logic [DCACHE_TAG_WIDTH-1:0]    address_tag;
    logic [DCACHE_DATA_WIDTH-1:0]   data_wdata;
    logic                           data_req;
    logic                           data_we;
    logic [DCACHE_DATA_WIDTH/8-1:0] data_be;
    logic [1:0]                     data_size;
    logic                           kill_req;
    logic                           tag_valid;
  } dcache_req_i_t;

  // Cache -> requester: grant and in-order response.
  typedef struct packed {
    logic                         data_gnt;
    logic                         data_rvalid;
    logic [DCACHE_DATA_WIDTH-1:0] data_rdata;
  } dcache_req_o_t;

endpackage

// File: rtl/dcache_owner_fifo.sv
// Purpose: in-order record of which requester owns each granted dcache request.
// Latency: push visible at head one cycle later; head/full/empty/count are registered state.
// Backpressure: push while full is accepted only together with a pop; pop while empty is ignored.
//
// Ports: clk, rst (sync, active-high); push/push_owner write the tail; pop retires the head;
//        full/empty/count report occupancy; head is the oldest owner (OWN_NONE when empty).
module dcache_owner_fifo
  import wt_cache_pkg::*;
#(
  parameter  int unsigned Depth = 4,
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  port_owner_e     push_owner,
  input  logic            pop,
  output logic            full,
  output logic            empty,
  output port_owner_e     head,
  output logic [CntW-1:0] count
);

  port_owner_e     mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? OWN_NONE : mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= push_owner;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count  <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      case ({do_push, do_pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Purpose: merges the CPU load port (strict priority) and the prefetch port onto one dcache load port.
// Latency: request/grant combinational; tag phase muxed from the owner registered at grant; rvalid/rdata combinational.
// Backpressure: no request forwarded while the owner FIFO is full; prefetch also held at MaxPfOutstanding in flight.
//
// Ports: clk, rst (sync, active-high); cpu_port_i/o and pf_port_i/o are the two requesters;
//        cache_port_o/i face the dcache; pf_inflight_o = prefetches awaiting rvalid;
//        pf_issued_o = saturating count of prefetch grants.
module dcache_port_arbiter
  import wt_cache_pkg::*;
#(
  parameter int unsigned MaxOutstanding   = 4,
  parameter int unsigned MaxPfOutstanding = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  dcache_req_i_t cpu_port_i,
  output dcache_req_o_t cpu_port_o,
  input  dcache_req_i_t pf_port_i,
  output dcache_req_o_t pf_port_o,
  output dcache_req_i_t cache_port_o,
  input  dcache_req_o_t cache_port_i,
  output logic [2:0]    pf_inflight_o,
  output logic [15:0]   pf_issued_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  port_owner_e     fifo_head;
  port_owner_e     push_owner;
  port_owner_e     tag_owner_q, tag_owner_d;
  logic            can_issue, sel_cpu, sel_pf;
  logic            grant, pf_grant, resp, pf_resp;

  // Full is taken before any same-cycle pop, so a full FIFO blocks new requests this cycle.
  assign can_issue  = !fifo_full;
  assign sel_cpu    = !rst && cpu_port_i.data_req && can_issue;
  assign sel_pf     = !rst && !sel_cpu && pf_port_i.data_req && can_issue &&
                      (pf_inflight_o < 3'(MaxPfOutstanding));
  assign grant      = (sel_cpu || sel_pf) && cache_port_i.data_gnt;
  assign pf_grant   = sel_pf && cache_port_i.data_gnt;
  assign push_owner = sel_pf ? OWN_PF : OWN_CPU;
  assign tag_owner_d = grant ? push_owner : OWN_NONE;

  // A response with nothing outstanding is dropped rather than popping garbage.
  assign resp    = !rst && cache_port_i.data_rvalid && !fifo_empty;
  assign pf_resp = resp && (fifo_head == OWN_PF);

  dcache_owner_fifo #(
    .Depth (MaxOutstanding)
  ) u_owner_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (grant),
    .push_owner (push_owner),
    .pop        (resp),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (fifo_head),
    .count      (fifo_count)
  );

  // Request fields follow this cycle's winner; tag fields follow last cycle's grant.
  always_comb begin
    cache_port_o = '0;
    if (sel_pf) begin
      cache_port_o.address_index = pf_port_i.address_index;
      cache_port_o.data_wdata    = pf_port_i.data_wdata;
      cache_port_o.data_we       = pf_port_i.data_we;
      cache_port_o.data_be       = pf_port_i.data_be;
      cache_port_o.data_size     = pf_port_i.data_size;
    end else begin
      cache_port_o.address_index = cpu_port_i.address_index;
      cache_port_o.data_wdata    = cpu_port_i.data_wdata;
      cache_port_o.data_we       = cpu_port_i.data_we;
      cache_port_o.data_be       = cpu_port_i.data_be;
      cache_port_o.data_size     = cpu_port_i.data_size;
    end
    cache_port_o.data_req = sel_cpu || sel_pf;

    if (tag_owner_q == OWN_PF) begin
      cache_port_o.address_tag = pf_port_i.address_tag;
      cache_port_o.tag_valid   = pf_port_i.tag_valid;
      cache_port_o.kill_req    = pf_port_i.kill_req;
    end else begin
      cache_port_o.address_tag = cpu_port_i.address_tag;
      if (tag_owner_q == OWN_CPU) begin
        cache_port_o.tag_valid = cpu_port_i.tag_valid;
        cache_port_o.kill_req  = cpu_port_i.kill_req;
      end
    end
    // tag_owner_q still holds pre-reset state during the reset cycle itself.
    if (rst) begin
      cache_port_o.tag_valid = 1'b0;
      cache_port_o.kill_req  = 1'b0;
    end
  end

  always_comb begin
    cpu_port_o             = '0;
    pf_port_o              = '0;
    cpu_port_o.data_gnt    = sel_cpu && cache_port_i.data_gnt;
    pf_port_o.data_gnt     = pf_grant;
    cpu_port_o.data_rvalid = resp && (fifo_head == OWN_CPU);
    pf_port_o.data_rvalid  = pf_resp;
    cpu_port_o.data_rdata  = cache_port_i.data_rdata;
    pf_port_o.data_rdata   = cache_port_i.data_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_owner_q   <= OWN_NONE;
      pf_inflight_o <= '0;
      pf_issued_o   <= '0;
    end else begin
      tag_owner_q <= tag_owner_d;
      case ({pf_grant, pf_resp})
        2'b10:   pf_inflight_o <= pf_inflight_o + 3'd1;
        2'b01:   pf_inflight_o <= pf_inflight_o - 3'd1;
        default: pf_inflight_o <= pf_inflight_o;
      endcase
      if (pf_grant && (pf_issued_o != 16'hFFFF)) begin
        pf_issued_o <= pf_issued_o + 16'd1;
      end
    end
  end

  a_rvalid_needs_owner: assert property (@(posedge clk) disable iff (rst)
    cache_port_i.data_rvalid |-> !fifo_empty)
    else $error("dcache rvalid with no outstanding request");

  a_count_bounded: assert property (@(posedge clk) disable iff (rst)
    fifo_count <= CntW'(MaxOutstanding))
    else $error("owner FIFO over capacity");

endmodule

// File: tb/tb_dcache_port_arbiter.sv
module tb_dcache_port_arbiter;
  import wt_cache_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  dcache_req_i_t cpu_i, pf_i, cache_o;
  dcache_req_o_t cpu_o, pf_o, cache_i;
  logic [2:0]    pf_inflight;
  logic [15:0]   pf_issued;

  int          n_chk  = 0;
  int          n_fail = 0;
  port_owner_e sb_q[$];
  port_owner_e mon_own;

  always #5 clk = ~clk;

  dcache_port_arbiter #(.MaxOutstanding(4), .MaxPfOutstanding(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_port_i    (cpu_i),
    .cpu_port_o    (cpu_o),
    .pf_port_i     (pf_i),
    .pf_port_o     (pf_o),
    .cache_port_o  (cache_o),
    .cache_port_i  (cache_i),
    .pf_inflight_o (pf_inflight),
    .pf_issued_o   (pf_issued)
  );

  // Response scoreboard: owners are queued when a grant is expected, retired on each cache rvalid.
  always @(negedge clk) begin
    if (!rst && cache_i.data_rvalid) begin
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL resp_underflow: rvalid seen with no expected owner");
      end else begin
        mon_own = sb_q.pop_front();
        if (cpu_o.data_rvalid !== (mon_own == OWN_CPU) || pf_o.data_rvalid !== (mon_own == OWN_PF)) begin
          n_fail++;
          $display("FAIL resp_route t=%0t: cpu_rvalid=%b pf_rvalid=%b, required owner %s",
                   $time, cpu_o.data_rvalid, pf_o.data_rvalid, mon_own.name());
        end
      end
      n_chk++;
      if (cpu_o.data_rdata !== cache_i.data_rdata || pf_o.data_rdata !== cache_i.data_rdata) begin
        n_fail++;
        $display("FAIL resp_rdata t=%0t: cpu=%h pf=%h required %h",
                 $time, cpu_o.data_rdata, pf_o.data_rdata, cache_i.data_rdata);
      end
    end else begin
      n_chk++;
      if (cpu_o.data_rvalid !== 1'b0 || pf_o.data_rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL spurious_rvalid t=%0t: cpu_rvalid=%b pf_rvalid=%b required 0/0",
                 $time, cpu_o.data_rvalid, pf_o.data_rvalid);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    cpu_i   = '0;
    pf_i    = '0;
    cache_i = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d responses still expected, required 0", sb_q.size());
    end
    rst = 1'b1;
    idle();
    next_cycle();
    next_cycle();
    rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    cpu_i.data_req = 1'b1; cpu_i.tag_valid = 1'b1; cpu_i.kill_req = 1'b1;
    pf_i.data_req  = 1'b1;
    cache_i.data_gnt = 1'b1;
    next_cycle();
    @(negedge clk);
    n_chk++;
    if (cpu_o.data_gnt !== 1'b0 || pf_o.data_gnt !== 1'b0 || cache_o.data_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req: cpu_gnt=%b pf_gnt=%b data_req=%b required 0", cpu_o.data_gnt, pf_o.data_gnt, cache_o.data_req);
    end
    n_chk++;
    if (cache_o.tag_valid !== 1'b0 || cache_o.kill_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tag: tag_valid=%b kill=%b required 0", cache_o.tag_valid, cache_o.kill_req);
    end
    n_chk++;
    if (pf_inflight !== 3'd0 || pf_issued !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: inflight=%0d issued=%0d required 0", pf_inflight, pf_issued);
    end
    next_cycle();
    rst = 1'b0;
    idle();
  endtask

  task automatic test_cpu_only();
    logic [11:0] idx [3];
    logic [19:0] tg  [3];
    idx = '{12'h010, 12'h018, 12'h020};
    tg  = '{20'hA0010, 20'hA0018, 20'hA0020};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      cpu_i = '0;
      cache_i = '0;
      cache_i.data_gnt = 1'b1;
      if (c < 3) begin
        cpu_i.data_req = 1'b1; cpu_i.address_index = idx[c]; cpu_i.data_be = 4'hF;
        sb_q.push_back(OWN_CPU);
      end
      if (c >= 1 && c <= 3) begin
        cpu_i.tag_valid = 1'b1; cpu_i.address_tag = tg[c-1];
      end
      if (c >= 3 && c <= 5) begin
        cache_i.data_rvalid = 1'b1; cache_i.data_rdata = $urandom;
      end
      @(negedge clk);
      n_chk++;
      if (cpu_o.data_gnt !== (c < 3) || pf_o.data_gnt !== 1'b0 || cache_o.data_req !== (c < 3)) begin
        n_fail++;
        $display("FAIL cpu_only_gnt c%0d: cpu_gnt=%b pf_gnt=%b req=%b required %b/0/%b",
                 c, cpu_o.data_gnt, pf_o.data_gnt, cache_o.data_req, c < 3, c < 3);
      end
      if (c < 3) begin
        n_chk++;
        if (cache_o.address_index !== idx[c]) begin
          n_fail++;
          $display("FAIL cpu_only_idx c%0d: %h required %h", c, cache_o.address_index, idx[c]);
        end
      end
      n_chk++;
      if (cache_o.tag_valid !== (c >= 1 && c <= 3)) begin
        n_fail++;
        $display("FAIL cpu_only_tagv c%0d: %b required %b", c, cache_o.tag_valid, c >= 1 && c <= 3);
      end
      if (c >= 1 && c <= 3) begin
        n_chk++;
        if (cache_o.address_tag !== tg[c-1]) begin
          n_fail++;
          $display("FAIL cpu_only_tag c%0d: %h required %h", c, cache_o.address_tag, tg[c-1]);
        end
      end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_both_req();
    do_reset();
    cache_i.data_gnt = 1'b1;
    // c0: both request, CPU wins
    cpu_i.data_req = 1'b1; cpu_i.address_index = 12'h030;
    pf_i.data_req  = 1'b1; pf_i.address_index  = 12'h040;
    sb_q.push_back(OWN_CPU);
    @(negedge clk);
    n_chk++;
    if (cpu_o.data_gnt !== 1'b1 || pf_o.data_gnt !== 1'b0 || cache_o.address_index !== 12'h030) begin
      n_fail++;
      $display("FAIL both_c0: cpu_gnt=%b pf_gnt=%b idx=%h required 1/0/030", cpu_o.data_gnt, pf_o.data_gnt, cache_o.address_index);
    end
    next_cycle();
    // c1: PF granted, CPU tag phase
    cpu_i.data_req = 1'b0; cpu_i.tag_valid = 1'b1; cpu_i.address_tag = 20'hC0030;
    sb_q.push_back(OWN_PF);
    @(negedge clk);
    n_chk++;
    if (cpu_o.data_gnt !== 1'b0 || pf_o.data_gnt !== 1'b1 || cache_o.address_index !== 12'h040) begin
      n_fail++;
      $display("FAIL both_c1_req: cpu_gnt=%b pf_gnt=%b idx=%h required 0/1/040", cpu_o.data_gnt, pf_o.data_gnt, cache_o.address_index);
    end
    n_chk++;
    if (cache_o.tag_valid !== 1'b1 || cache_o.address_tag !== 20'hC0030) begin
      n_fail++;
      $display("FAIL both_c1_tag: tagv=%b tag=%h required 1/C0030", cache_o.tag_valid, cache_o.address_tag);
    end
    next_cycle();
    // c2: PF tag phase; CPU tag lines deliberately busy with a different value
    pf_i.data_req = 1'b0; pf_i.tag_valid = 1'b1; pf_i.address_tag = 20'hF0040;
    cpu_i.address_tag = 20'h11111;
    @(negedge clk);
    n_chk++;
    if (cache_o.tag_valid !== 1'b1 || cache_o.address_tag !== 20'hF0040 || cache_o.data_req !== 1'b0) begin
      n_fail++;
      $display("FAIL both_c2_tag: tagv=%b tag=%h req=%b required 1/F0040/0", cache_o.tag_valid, cache_o.address_tag, cache_o.data_req);
    end
    n_chk++;
    if (pf_issued !== 16'd1 || pf_inflight !== 3'd1) begin
      n_fail++;
      $display("FAIL both_c2_cnt: issued=%0d inflight=%0d required 1/1", pf_issued, pf_inflight);
    end
    next_cycle();
    idle();
    for (int c = 3; c < 5; c++) begin
      cache_i.data_rvalid = 1'b1; cache_i.data_rdata = $urandom;
      next_cycle();
    end
    idle();
    @(negedge clk);
    n_chk++;
    if (pf_issued !== 16'd1 || pf_inflight !== 3'd0) begin
      n_fail++;
      $display("FAIL both_end_cnt: issued=%0d inflight=%0d required 1/0", pf_issued, pf_inflight);
    end
    next_cycle();
  endtask

  task automatic test_pf_throttle();
    logic [7:0] gnt_v;
    logic [7:0] rv_v;
    int         infl [8];
    gnt_v = 8'b0001_0011;
    rv_v  = 8'b0110_1000;
    infl  = '{0, 1, 2, 2, 1, 2, 1, 0};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      idle();
      cache_i.data_gnt = 1'b1;
      pf_i.data_req    = (c <= 4);
      pf_i.address_index = 12'h040 + 12'(c);
      pf_i.tag_valid   = 1'b1;
      if (gnt_v[c]) sb_q.push_back(OWN_PF);
      if (rv_v[c]) begin
        cache_i.data_rvalid = 1'b1; cache_i.data_rdata = $urandom;
      end
      @(negedge clk);
      n_chk++;
      if (pf_o.data_gnt !== gnt_v[c] || cache_o.data_req !== gnt_v[c] || cpu_o.data_gnt !== 1'b0) begin
        n_fail++;
        $display("FAIL throttle_gnt c%0d: pf_gnt=%b req=%b cpu_gnt=%b required %b/%b/0",
                 c, pf_o.data_gnt, cache_o.data_req, cpu_o.data_gnt, gnt_v[c], gnt_v[c]);
      end
      n_chk++;
      if (pf_inflight !== 3'(infl[c])) begin
        n_fail++;
        $display("FAIL throttle_inflight c%0d: %0d required %0d", c, pf_inflight, infl[c]);
      end
      next_cycle();
    end
    @(negedge clk);
    n_chk++;
    if (pf_issued !== 16'd3) begin
      n_fail++;
      $display("FAIL throttle_issued: %0d required 3", pf_issued);
    end
    next_cycle();
    idle();
  endtask

  task automatic test_fifo_full();
    logic [12:0] gnt_v;
    logic [12:0] rv_v;
    gnt_v = 13'b0_0000_1100_1111;
    rv_v  = 13'b1_1110_0110_0000;
    do_reset();
    for (int c = 0; c < 13; c++) begin
      idle();
      cache_i.data_gnt = 1'b1;
      cpu_i.data_req = (c <= 8);
      cpu_i.address_index = 12'h100 + 12'(c);
      if (gnt_v[c]) sb_q.push_back(OWN_CPU);
      if (rv_v[c]) begin
        cache_i.data_rvalid = 1'b1; cache_i.data_rdata = $urandom;
      end
      @(negedge clk);
      n_chk++;
      if (cpu_o.data_gnt !== gnt_v[c] || cache_o.data_req !== gnt_v[c]) begin
        n_fail++;
        $display("FAIL full_gnt c%0d: cpu_gnt=%b req=%b required %b", c, cpu_o.data_gnt, cache_o.data_req, gnt_v[c]);
      end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_kill();
    do_reset();
    pf_i.kill_req = 1'b1;
    cache_i.data_gnt = 1'b1;
    cpu_i.data_req = 1'b1; cpu_i.address_index = 12'h050;
    sb_q.push_back(OWN_CPU);
    @(negedge clk);
    n_chk++;
    if (cache_o.kill_req !== 1'b0 || cpu_o.data_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL kill_c0: kill=%b cpu_gnt=%b required 0/1", cache_o.kill_req, cpu_o.data_gnt);
    end
    next_cycle();
    cpu_i.data_req = 1'b0; cpu_i.tag_valid = 1'b1; cpu_i.kill_req = 1'b1;
    @(negedge clk);
    n_chk++;
    if (cache_o.kill_req !== 1'b1 || cache_o.tag_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL kill_c1: kill=%b tagv=%b required 1/1", cache_o.kill_req, cache_o.tag_valid);
    end
    next_cycle();
    @(negedge clk);
    n_chk++;
    if (cache_o.kill_req !== 1'b0 || cache_o.tag_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_c2: kill=%b tagv=%b required 0/0", cache_o.kill_req, cache_o.tag_valid);
    end
    next_cycle();
    idle();
    cache_i.data_rvalid = 1'b1; cache_i.data_rdata = $urandom;
    next_cycle();
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    cache_i.data_gnt = 1'b1;
    pf_i.data_req = 1'b1;
    next_cycle();
    pf_i.data_req = 1'b0; cpu_i.data_req = 1'b1;
    next_cycle();
    next_cycle();
    // reset cycle with everything asserted
    rst = 1'b1;
    pf_i.data_req = 1'b1; cpu_i.tag_valid = 1'b1; pf_i.tag_valid = 1'b1;
    cpu_i.kill_req = 1'b1; pf_i.kill_req = 1'b1;
    cache_i.data_rvalid = 1'b1; cache_i.data_rdata = $urandom;
    @(negedge clk);
    n_chk++;
    if (cpu_o.data_gnt !== 1'b0 || pf_o.data_gnt !== 1'b0 || cache_o.data_req !== 1'b0 ||
        cache_o.tag_valid !== 1'b0 || cache_o.kill_req !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: cpu_gnt=%b pf_gnt=%b req=%b tagv=%b kill=%b required all 0",
               cpu_o.data_gnt, pf_o.data_gnt, cache_o.data_req, cache_o.tag_valid, cache_o.kill_req);
    end
    next_cycle();
    rst = 1'b0;
    sb_q.delete();
    idle();
    cpu_i.tag_valid = 1'b1;
    @(negedge clk);
    n_chk++;
    if (pf_inflight !== 3'd0 || pf_issued !== 16'd0 || dut.u_owner_fifo.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_state: inflight=%0d issued=%0d empty=%b required 0/0/1",
               pf_inflight, pf_issued, dut.u_owner_fifo.empty);
    end
    n_chk++;
    if (cache_o.tag_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_tagowner: tagv=%b required 0", cache_o.tag_valid);
    end
    next_cycle();
    // a fresh CPU request must get its response even though a stale PF entry was at the head
    idle();
    cache_i.data_gnt = 1'b1; cpu_i.data_req = 1'b1;
    sb_q.push_back(OWN_CPU);
    next_cycle();
    idle();
    cpu_i.tag_valid = 1'b1;
    next_cycle();
    idle();
    cache_i.data_rvalid = 1'b1; cache_i.data_rdata = $urandom;
    next_cycle();
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_cpu_only();
    test_both_req();
    test_pf_throttle();
    test_fifo_full();
    test_kill();
    test_reset_mid();
    next_cycle();
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_final: %0d responses never arrived, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
